sync_ram_ctrl: RTL and testbench

Parametrised single-port synchronous memory with a request/acknowledge handshake. It replaces the fixed 512x32 RAM that uses strobe-derived clocking. It adds byte-lane writes, configurable read latency, and hardware zero-initialisation on reset. It sits between the MiniSRC datapath memory interface (MAR/MDR) and storage, and is clocked from the system clock.

---
 rtl/sync_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_sync_ram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with req/ack handshake, byte-lane writes,
// configurable read latency and optional zero sweep after reset.
module sync_ram_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 9,
  parameter int READ_LATENCY  = 1,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                    clck,
  input  logic                    clr,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ready,
  output logic                    ack,
  output logic                    init_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Wait-state count loaded at accept; completion fires when it reaches zero.
  localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic [1:0]              lat_cnt_q;
  logic [DATA_WIDTH-1:0]   rd_buf_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    ready_q;
  logic                    ack_q;
  logic                    init_busy_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NB-1:0]           mem_wbe;

  // The init sweep and user writes share the single write port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    mem_wbe   = be;
    if (!clr) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
      end else if (state_q == ST_IDLE && req && we) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM; zeroing is the INIT sweep's job.
  always_ff @(posedge clck) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clck) begin
    if (clr) begin
      state_q     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
      ready_q     <= !INIT_ON_RESET;
      init_busy_q <= INIT_ON_RESET;
      ack_q       <= 1'b0;
      data_out_q  <= '0;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            init_busy_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req) begin
            if (we) begin
              ack_q <= 1'b1;
            end else if (READ_LATENCY == 1) begin
              data_out_q <= mem_q[addr];
              ack_q      <= 1'b1;
            end else begin
              // Data is captured now; addr may change freely during the wait.
              rd_buf_q  <= mem_q[addr];
              lat_cnt_q <= LAT_LOAD;
              state_q   <= ST_RD_WAIT;
              ready_q   <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt_q == 2'd0) begin
            data_out_q <= rd_buf_q;
            ack_q      <= 1'b1;
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign ack       = ack_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Three sync_ram_ctrl configurations checked every cycle against a
// transaction-level model, plus directed cases with literal expectations.
module tb_sync_ram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr_a   [NI];
  logic          req_a   [NI];
  logic          we_a    [NI];
  logic [AW-1:0] addr_a  [NI];
  logic [3:0]    be_a    [NI];
  logic [DW-1:0] din_a   [NI];
  logic [DW-1:0] dout_a  [NI];
  logic          ready_a [NI];
  logic          ack_a   [NI];
  logic          busy_a  [NI];

  // 0: defaults, 1: READ_LATENCY=3, 2: INIT_ON_RESET=0
  sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_ON_RESET(1'b1)) u_rl1 (
    .clck(clk), .clr(clr_a[0]), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]), .be(be_a[0]),
    .data_in(din_a[0]), .data_out(dout_a[0]), .ready(ready_a[0]), .ack(ack_a[0]), .init_busy(busy_a[0]));
  sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .INIT_ON_RESET(1'b1)) u_rl3 (
    .clck(clk), .clr(clr_a[1]), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]), .be(be_a[1]),
    .data_in(din_a[1]), .data_out(dout_a[1]), .ready(ready_a[1]), .ack(ack_a[1]), .init_busy(busy_a[1]));
  sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_ON_RESET(1'b0)) u_noinit (
    .clck(clk), .clr(clr_a[2]), .req(req_a[2]), .we(we_a[2]), .addr(addr_a[2]), .be(be_a[2]),
    .data_in(din_a[2]), .data_out(dout_a[2]), .ready(ready_a[2]), .ack(ack_a[2]), .init_busy(busy_a[2]));

  function automatic int rl_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit init_of(input int k);
    return (k != 2);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: remaining init cycles, remaining read cycles, and
  // the value the pending read will return.
  logic [DW-1:0] m_mem   [NI][DEPTH];
  int            m_init  [NI];
  int            m_pend  [NI];
  logic [DW-1:0] m_pdata [NI];
  logic          m_ack   [NI];
  logic [DW-1:0] m_dout  [NI];
  bit            m_valid [NI];

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (clr_a[k]) begin
        m_valid[k] = 1'b1;
        m_ack[k]   = 1'b0;
        m_dout[k]  = '0;
        m_pend[k]  = 0;
        m_init[k]  = init_of(k) ? DEPTH : 0;
        if (init_of(k)) for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;
      end else if (!m_valid[k]) begin
        m_ack[k] = 1'b0;
      end else if (m_init[k] > 0) begin
        m_init[k]--;
        m_ack[k] = 1'b0;
      end else if (m_pend[k] > 0) begin
        m_pend[k]--;
        m_ack[k] = (m_pend[k] == 0);
        if (m_pend[k] == 0) m_dout[k] = m_pdata[k];
      end else begin
        m_ack[k] = 1'b0;
        if (req_a[k]) begin
          if (we_a[k]) begin
            for (int b = 0; b < 4; b++)
              if (be_a[k][b]) m_mem[k][addr_a[k]][8*b +: 8] = din_a[k][8*b +: 8];
            m_ack[k] = 1'b1;
          end else if (rl_of(k) == 1) begin
            m_dout[k] = m_mem[k][addr_a[k]];
            m_ack[k]  = 1'b1;
          end else begin
            m_pend[k]  = rl_of(k) - 1;
            m_pdata[k] = m_mem[k][addr_a[k]];
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (m_valid[k]) begin
        check($sformatf("ack%0d", k), 32'(ack_a[k]), 32'(m_ack[k]));
        check($sformatf("ready%0d", k), 32'(ready_a[k]), 32'(m_init[k] == 0 && m_pend[k] == 0));
        check($sformatf("init_busy%0d", k), 32'(busy_a[k]), 32'(m_init[k] != 0));
        check($sformatf("data_out%0d", k), dout_a[k], m_dout[k]);
      end
    end
  end

  // One request; returns data_out at ack and the ack latency in cycles.
  task automatic xfer(input int k, input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                      input logic [DW-1:0] d, output logic [DW-1:0] q, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready_a[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_a[k] = 1'b1; we_a[k] = w; addr_a[k] = a; be_a[k] = b; din_a[k] = d;
    @(negedge clk);
    req_a[k] = 1'b0;
    lat = 1;
    while (!ack_a[k] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    q = dout_a[k];
  endtask

  task automatic pulse_clr(input int k);
    @(negedge clk);
    clr_a[k] = 1'b1;
    @(negedge clk);
    clr_a[k] = 1'b0;
  endtask

  task automatic wait_init(input int k, output int cycles, output int acks);
    cycles = 0;
    acks   = 0;
    while (busy_a[k] && cycles < 2000) begin
      if (ack_a[k]) acks++;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic rand_phase(input int k, input int ncyc, input int clr_mod);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      clr_a[k] = (clr_mod > 0) && ($urandom_range(0, clr_mod - 1) == 0);
      req_a[k] = 1'($urandom);
      we_a[k]  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       addr_a[k] = AW'($urandom_range(0, 7));
        1:       addr_a[k] = AW'($urandom_range(DEPTH - 4, DEPTH - 1));
        default: addr_a[k] = AW'($urandom_range(0, DEPTH - 1));
      endcase
      be_a[k]  = 4'($urandom);
      din_a[k] = $urandom;
    end
    @(negedge clk);
    clr_a[k] = 1'b0;
    req_a[k] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] q;
    int lat, n, acks;
    for (int k = 0; k < NI; k++) begin
      clr_a[k] = 1'b1; req_a[k] = 1'b0; we_a[k] = 1'b0;
      addr_a[k] = '0; be_a[k] = '0; din_a[k] = '0;
    end
    @(negedge clk);
    check("reset_ready0", 32'(ready_a[0]), 32'd0);
    check("reset_ready2", 32'(ready_a[2]), 32'd1);
    check("reset_dout0", dout_a[0], 32'd0);
    for (int k = 0; k < NI; k++) clr_a[k] = 1'b0;

    // Init sweep length and first read
    pulse_clr(0);
    wait_init(0, n, acks);
    check("t1_init_cycles", 32'(n), 32'd512);
    check("t1_ready_after_init", 32'(ready_a[0]), 32'd1);
    xfer(0, 1'b0, 9'd0, 4'h0, '0, q, lat);
    check("t1_rd_lat", 32'(lat), 32'd1);
    check("t1_rd_data", q, 32'd0);

    // Full-word writes, top address
    xfer(0, 1'b1, 9'd0, 4'hF, 32'd86, q, lat);
    check("t2_wr_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 9'd0, 4'h0, '0, q, lat);
    check("t2_rd0", q, 32'd86);
    xfer(0, 1'b1, 9'd511, 4'hF, 32'd2, q, lat);
    xfer(0, 1'b0, 9'd511, 4'h0, '0, q, lat);
    check("t2_rd511", q, 32'd2);
    xfer(0, 1'b0, 9'd0, 4'h0, '0, q, lat);
    check("t2_rd0_again", q, 32'd86);

    // Byte lanes and be=0
    xfer(0, 1'b1, 9'd5, 4'hF, 32'hAABBCCDD, q, lat);
    xfer(0, 1'b1, 9'd5, 4'b0101, 32'h11223344, q, lat);
    xfer(0, 1'b0, 9'd5, 4'h0, '0, q, lat);
    check("t3_lanes", q, 32'hAA22CC44);
    xfer(0, 1'b1, 9'd5, 4'h0, 32'hFFFFFFFF, q, lat);
    check("t3_be0_lat", 32'(lat), 32'd1);
    check("t3_be0_dout_held", q, 32'hAA22CC44);
    xfer(0, 1'b0, 9'd5, 4'h0, '0, q, lat);
    check("t3_be0_unchanged", q, 32'hAA22CC44);

    // READ_LATENCY=3 timing, ignored req in wait, back-to-back writes
    xfer(1, 1'b1, 9'd7, 4'hF, 32'h12345678, q, lat);
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 9'd7;
    @(negedge clk);
    req_a[1] = 1'b0;
    check("t4_wait1_ready", 32'(ready_a[1]), 32'd0);
    check("t4_wait1_ack", 32'(ack_a[1]), 32'd0);
    req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 9'd8; be_a[1] = 4'hF; din_a[1] = 32'hDEADBEEF;
    @(negedge clk);
    req_a[1] = 1'b0; addr_a[1] = 9'd9;
    check("t4_wait2_ready", 32'(ready_a[1]), 32'd0);
    check("t4_wait2_ack", 32'(ack_a[1]), 32'd0);
    @(negedge clk);
    check("t4_ack_at3", 32'(ack_a[1]), 32'd1);
    check("t4_data_at3", dout_a[1], 32'h12345678);
    check("t4_ready_at3", 32'(ready_a[1]), 32'd1);
    @(negedge clk);
    check("t4_ack_single", 32'(ack_a[1]), 32'd0);
    xfer(1, 1'b0, 9'd8, 4'h0, '0, q, lat);
    check("t4_rd_lat", 32'(lat), 32'd3);
    check("t4_ignored_write", q, 32'd0);
    req_a[1] = 1'b1; we_a[1] = 1'b1; be_a[1] = 4'hF; addr_a[1] = 9'd20; din_a[1] = 32'd100;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t4_b2b_ack", 32'(ack_a[1]), 32'd1);
      addr_a[1] = AW'(20 + i); din_a[1] = 32'(100 + i);
    end
    @(negedge clk);
    check("t4_b2b_ack", 32'(ack_a[1]), 32'd1);
    req_a[1] = 1'b0;
    @(negedge clk);
    check("t4_b2b_end", 32'(ack_a[1]), 32'd0);
    xfer(1, 1'b0, 9'd22, 4'h0, '0, q, lat);
    check("t4_b2b_data", q, 32'd102);

    // Reset during a pending read
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 9'd20;
    @(negedge clk);
    req_a[1] = 1'b0; clr_a[1] = 1'b1;
    @(negedge clk);
    clr_a[1] = 1'b0;
    wait_init(1, n, acks);
    for (int i = 0; i < 4; i++) begin
      if (ack_a[1]) acks++;
      @(negedge clk);
    end
    check("t5_no_ack", 32'(acks), 32'd0);
    check("t5_init_cycles", 32'(n), 32'd512);
    xfer(1, 1'b0, 9'd20, 4'h0, '0, q, lat);
    check("t5_zeroed", q, 32'd0);

    // No init sweep: contents survive reset
    xfer(2, 1'b1, 9'd3, 4'hF, 32'd7, q, lat);
    pulse_clr(2);
    check("t6_ready", 32'(ready_a[2]), 32'd1);
    check("t6_dout_cleared", dout_a[2], 32'd0);
    xfer(2, 1'b0, 9'd3, 4'h0, '0, q, lat);
    check("t6_lat", 32'(lat), 32'd1);
    check("t6_kept", q, 32'd7);

    // Give the un-initialised memory known contents before random reads
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      req_a[2] = 1'b1; we_a[2] = 1'b1; be_a[2] = 4'hF;
      addr_a[2] = AW'(i); din_a[2] = $urandom;
    end
    @(negedge clk);
    req_a[2] = 1'b0;

    rand_phase(0, 1500, 500);
    rand_phase(1, 2000, 700);
    rand_phase(2, 1500, 50);
    for (int i = 0; i < 8; i++) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
